// File: rtl/mskand_hpc3_rnd_feeder_if.sv
// Handshake bundle between the PRNG stream, the randomness feeder and the HPC3 gadget bank.
// The slave modport is the feeder. The master modport is its environment: the PRNG source plus the gadget consumers.
interface mskand_hpc3_rnd_feeder_if #(
    parameter int W_IN  = 32,
    parameter int RND_W = 2
);
    logic [W_IN-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [RND_W-1:0] rnd_out;
    logic             rnd_valid;
    logic             rnd_take;
    logic             underflow;

    modport slave (
        input  in_data, in_valid, flush, rnd_take,
        output in_ready, rnd_out, rnd_valid, underflow
    );

    modport master (
        output in_data, in_valid, flush, rnd_take,
        input  in_ready, rnd_out, rnd_valid, underflow
    );
endinterface

// File: rtl/mskand_hpc3_rnd_feeder.sv
// Packs W_IN-bit PRNG beats into one RND_W-bit randomness word for NG HPC3 gadgets.
// Every presented bit is used at most once: the buffer is cleared on transfer and the word is zeroed on consumption.
module mskand_hpc3_rnd_feeder #(
    parameter int d    = 2,
    parameter int NG   = 1,
    parameter int W_IN = 32
) (
    input logic                    clk,
    input logic                    rst,
    mskand_hpc3_rnd_feeder_if.slave bus
);
    localparam int RND_W  = NG * d * (d - 1);
    localparam int NCHUNK = (RND_W + W_IN - 1) / W_IN;
    localparam int BUF_W  = NCHUNK * W_IN;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {FILLING, FULL} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUF_W-1:0]   fill_buf_q, fill_buf_d;
    logic [RND_W-1:0]   rnd_out_q, rnd_out_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic               underflow_q, underflow_d;

    logic accept;
    logic xfer;

    // in_ready decodes the state register only, so rnd_take never reaches it combinationally.
    assign bus.in_ready  = (state_q == FILLING) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = (state_q == FULL) && (!rnd_valid_q || bus.rnd_take);

    assign bus.rnd_out   = rnd_out_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.underflow = underflow_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_buf_d  = fill_buf_q;
        rnd_out_d   = rnd_out_q;
        rnd_valid_d = rnd_valid_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            state_d     = FILLING;
            cnt_d       = '0;
            fill_buf_d  = '0;
            rnd_out_d   = '0;
            rnd_valid_d = 1'b0;
        end else begin
            if (bus.rnd_take && !rnd_valid_q)
                underflow_d = 1'b1;

            // A transfer clears the buffer so these bits cannot be presented a second time.
            if (xfer) begin
                rnd_out_d   = fill_buf_q[RND_W-1:0];
                rnd_valid_d = 1'b1;
                fill_buf_d  = '0;
                state_d     = FILLING;
            end else if (bus.rnd_take && rnd_valid_q) begin
                rnd_out_d   = '0;
                rnd_valid_d = 1'b0;
            end

            if (accept) begin
                fill_buf_d[int'(cnt_q)*W_IN +: W_IN] = bus.in_data;
                if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                    cnt_d   = '0;
                    state_d = FULL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the fill buffer is reset along with the control state, so randomness collected before a reset cannot appear on rnd_out afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILLING;
            cnt_q       <= '0;
            fill_buf_q  <= '0;
            rnd_out_q   <= '0;
            rnd_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep all registers sampling the same pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_buf_q  <= fill_buf_d;
            rnd_out_q   <= rnd_out_d;
            rnd_valid_q <= rnd_valid_d;
            underflow_q <= underflow_d;
        end
    end

`ifndef SYNTHESIS
    int unsigned beats_since_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beats_since_q <= 0;
        else if (bus.flush || xfer)
            beats_since_q <= 0;
        else if (accept)
            beats_since_q <= beats_since_q + 1;
    end

    a_word_from_nchunk_beats: assert property (
        @(posedge clk) disable iff (rst) (xfer && !bus.flush) |-> (beats_since_q == NCHUNK)
    );
`endif
endmodule

// File: tb/tb_mskand_hpc3_rnd_feeder.sv
// Directed checks on a d=2/NG=3/W_IN=4 feeder, plus a scoreboarded stall/take run on a d=3/NG=2/W_IN=5 feeder.
module tb_mskand_hpc3_rnd_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    mskand_hpc3_rnd_feeder_if #(.W_IN(4), .RND_W(6))  bus_a ();
    mskand_hpc3_rnd_feeder_if #(.W_IN(5), .RND_W(12)) bus_b ();

    mskand_hpc3_rnd_feeder #(.d(2), .NG(3), .W_IN(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    mskand_hpc3_rnd_feeder #(.d(3), .NG(2), .W_IN(5)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.flush = 1'b0; bus_a.rnd_take = 1'b0;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.flush = 1'b0; bus_b.rnd_take = 1'b0;
        cyc();
        n_checks++;
        if (bus_a.rnd_valid !== 1'b0) $display("FAIL reset_rnd_valid: got %b want 0", bus_a.rnd_valid); else n_pass++;
        n_checks++;
        if (bus_a.rnd_out !== 6'h00) $display("FAIL reset_rnd_out: got %h want 00", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.underflow !== 1'b0) $display("FAIL reset_underflow: got %b want 0", bus_a.underflow); else n_pass++;
        n_checks++;
        if (bus_a.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus_a.in_ready); else n_pass++;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        n_checks++;
        if (bus_a.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus_a.in_ready); else n_pass++;
    endtask

    task automatic test_fill();
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'hA;
        cyc();
        bus_a.in_data = 4'h5;
        cyc();
        bus_a.in_valid = 1'b0;
        n_checks++;
        if (bus_a.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus_a.in_ready); else n_pass++;
        n_checks++;
        if (bus_a.rnd_valid !== 1'b0) $display("FAIL full_rnd_valid_latency: got %b want 0", bus_a.rnd_valid); else n_pass++;
        cyc();
        n_checks++;
        if (bus_a.rnd_valid !== 1'b1) $display("FAIL first_word_valid: got %b want 1", bus_a.rnd_valid); else n_pass++;
        n_checks++;
        if (bus_a.rnd_out !== 6'h1A) $display("FAIL first_word_value: got %h want 1a", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.in_ready !== 1'b1) $display("FAIL refill_in_ready: got %b want 1", bus_a.in_ready); else n_pass++;
    endtask

    task automatic test_hold_and_refresh();
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'h3;
        cyc();
        bus_a.in_data = 4'hC;
        cyc();
        bus_a.in_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (bus_a.rnd_out !== 6'h1A) $display("FAIL hold_rnd_out: got %h want 1a", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.in_ready !== 1'b0) $display("FAIL hold_in_ready: got %b want 0", bus_a.in_ready); else n_pass++;
        bus_a.rnd_take = 1'b1;
        cyc();
        n_checks++;
        if (bus_a.rnd_out !== 6'h03) $display("FAIL refresh_rnd_out: got %h want 03", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.rnd_valid !== 1'b1) $display("FAIL refresh_no_bubble: got %b want 1", bus_a.rnd_valid); else n_pass++;
        cyc();
        bus_a.rnd_take = 1'b0;
        n_checks++;
        if (bus_a.rnd_valid !== 1'b0) $display("FAIL consume_rnd_valid: got %b want 0", bus_a.rnd_valid); else n_pass++;
        n_checks++;
        if (bus_a.rnd_out !== 6'h00) $display("FAIL consume_zeroed: got %h want 00", bus_a.rnd_out); else n_pass++;
    endtask

    task automatic test_underflow();
        n_checks++;
        if (bus_a.underflow !== 1'b0) $display("FAIL underflow_idle: got %b want 0", bus_a.underflow); else n_pass++;
        bus_a.rnd_take = 1'b1;
        cyc();
        bus_a.rnd_take = 1'b0;
        n_checks++;
        if (bus_a.underflow !== 1'b1) $display("FAIL underflow_set: got %b want 1", bus_a.underflow); else n_pass++;
        n_checks++;
        if (bus_a.rnd_out !== 6'h00) $display("FAIL underflow_rnd_out: got %h want 00", bus_a.rnd_out); else n_pass++;
    endtask

    task automatic test_flush();
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'hF;
        cyc();
        bus_a.flush = 1'b1; bus_a.in_data = 4'h7;
        cyc();
        bus_a.flush = 1'b0; bus_a.in_valid = 1'b0;
        n_checks++;
        if (dut_a.cnt_q !== 1'b0) $display("FAIL flush_cnt: got %0d want 0", dut_a.cnt_q); else n_pass++;
        n_checks++;
        if (dut_a.fill_buf_q !== 8'h00) $display("FAIL flush_buf: got %h want 00", dut_a.fill_buf_q); else n_pass++;
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'h1;
        cyc();
        bus_a.in_data = 4'h2;
        cyc();
        bus_a.in_valid = 1'b0;
        cyc();
        n_checks++;
        if (bus_a.rnd_out !== 6'h21) $display("FAIL flush_next_word: got %h want 21", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.rnd_valid !== 1'b1) $display("FAIL flush_next_valid: got %b want 1", bus_a.rnd_valid); else n_pass++;
        n_checks++;
        if (bus_a.underflow !== 1'b1) $display("FAIL underflow_sticky: got %b want 1", bus_a.underflow); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        n_checks++;
        if (bus_a.rnd_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", bus_a.rnd_valid); else n_pass++;
        n_checks++;
        if (bus_a.rnd_out !== 6'h00) $display("FAIL async_rst_out: got %h want 00", bus_a.rnd_out); else n_pass++;
        n_checks++;
        if (bus_a.in_ready !== 1'b0) $display("FAIL async_rst_ready: got %b want 0", bus_a.in_ready); else n_pass++;
        n_checks++;
        if (bus_a.underflow !== 1'b0) $display("FAIL async_rst_underflow: got %b want 0", bus_a.underflow); else n_pass++;
        #2;
        rst_a = 1'b0;
        #1;
        n_checks++;
        if (bus_a.in_ready !== 1'b1) $display("FAIL async_release_ready: got %b want 1", bus_a.in_ready); else n_pass++;
        bus_a.flush = 1'b1; bus_a.rnd_take = 1'b1;
        cyc();
        bus_a.flush = 1'b0; bus_a.rnd_take = 1'b0;
        n_checks++;
        if (bus_a.underflow !== 1'b0) $display("FAIL flush_take_underflow: got %b want 0", bus_a.underflow); else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'h9;
        cyc();
        bus_a.in_valid = 1'b0;
        #2 rst_a = 1'b1;
        #1 rst_a = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = 4'h4;
        cyc();
        bus_a.in_data = 4'h6;
        cyc();
        bus_a.in_valid = 1'b0;
        cyc();
        n_checks++;
        if (bus_a.rnd_out !== 6'h24) $display("FAIL mid_fill_reset_word: got %h want 24", bus_a.rnd_out); else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [4:0]  beats[$];
        logic [11:0] exp_q[$];
        logic [14:0] cat;
        logic [11:0] want;
        int          consumed;
        consumed = 0;
        for (int i = 0; i < 600; i++) begin
            bus_b.in_valid = ($urandom_range(0, 9) < 7);
            bus_b.in_data  = 5'($urandom);
            bus_b.rnd_take = (i < 580) ? (bus_b.rnd_valid && ($urandom_range(0, 2) != 0)) : bus_b.rnd_valid;
            if (i >= 580) bus_b.in_valid = 1'b0;
            @(negedge clk);
            if (bus_b.in_valid && bus_b.in_ready) begin
                beats.push_back(bus_b.in_data);
                if (beats.size() == 3) begin
                    cat = {beats[2], beats[1], beats[0]};
                    exp_q.push_back(cat[11:0]);
                    beats.delete();
                end
            end
            if (bus_b.rnd_take && bus_b.rnd_valid) begin
                n_checks++;
                consumed++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_word_unexpected: got %h want none pending", bus_b.rnd_out);
                end else begin
                    want = exp_q.pop_front();
                    if (bus_b.rnd_out !== want) $display("FAIL stream_word: got %h want %h", bus_b.rnd_out, want);
                    else n_pass++;
                end
            end
            cyc();
        end
        n_checks++;
        if (consumed < 40) $display("FAIL stream_throughput: got %0d words want at least 40", consumed); else n_pass++;
        n_checks++;
        if (bus_b.underflow !== 1'b0) $display("FAIL stream_underflow: got %b want 0", bus_b.underflow); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold_and_refresh();
        test_underflow();
        test_flush();
        test_async_reset();
        test_reset_mid_fill();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mskand_hpc3_rnd_feeder.md
Name: mskand_hpc3_rnd_feeder

Overview:
- Upstream stage of the HPC3 cross-domain AND gadgets. Collects fresh bits from the PRNG stream (valid/ready, W_IN bits per beat) and packs them into one full-width randomness word for a bank of NG gadgets.
- Presents the word on the gadgets' rnd bus with a valid flag.
- Guarantees single use: every presented bit is consumed at most once, and it is dropped or zeroed after consumption.

Parameters:
- d, 2: number of shares per gadget; must be >= 2.
- NG, 1: number of HPC3 gadgets fed in parallel.
- W_IN, 32: PRNG beat width in bits.
- Derived (localparam) RND_W = NG*d*(d-1): output word width, i.e. the gadget rnd width times NG.
- Derived (localparam) NCHUNK = ceil(RND_W/W_IN).
- Derived (localparam) BUF_W = NCHUNK*W_IN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  W_IN  PRNG beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted at an edge where in_valid && in_ready.
- flush  in  1  synchronous discard of all buffered randomness.
- rnd_out  out  RND_W  randomness word to the gadgets; gadget k uses slice [k*d*(d-1) +: d*(d-1)].
- rnd_valid  out  1  rnd_out is fresh.
- rnd_take  in  1  gadgets consume rnd_out this cycle.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, active-high). While rst is high:
  - fill FSM = FILLING, cnt = 0, buffer = 0;
  - rnd_out = 0, rnd_valid = 0, underflow = 0;
  - in_ready = 0 (gated by rst).
- Fill FSM: two states, FILLING and FULL.
  - in_ready = (state == FILLING) && !rst. It is a registered decode and has no combinational path from rnd_take.
  - FILLING: on an accepted beat, buf[cnt*W_IN +: W_IN] <= in_data and cnt increments. The first beat lands in the LSBs.
  - FILLING: if the accepted beat has cnt == NCHUNK-1, cnt wraps to 0 and the state goes to FULL.
- Transfer condition: xfer = (state == FULL) && (!rnd_valid || rnd_take).
  - On xfer: rnd_out <= buf[RND_W-1:0], rnd_valid <= 1, buf <= 0, state <= FILLING.
  - Buffer bits [BUF_W-1:RND_W] are discarded.
  - Latency: rnd_valid rises one edge after the edge that accepts the last chunk.
- Consumption without refill: rnd_take && rnd_valid && !xfer gives rnd_valid <= 0 and rnd_out <= 0 (zeroed, never left stale).
- Take and transfer in the same cycle: the new word replaces the old one, rnd_valid stays 1 with no bubble.
- Steady-state throughput: one word per NCHUNK+1 cycles when the gadgets take immediately.
- Underflow: rnd_take && !rnd_valid sets underflow <= 1, sticky until rst. rnd_out is not modified.
- Flush, with highest priority at that edge:
  - buf, cnt, rnd_out <= 0; rnd_valid <= 0; state <= FILLING.
  - A beat handshaken in the same cycle is dropped.
  - A concurrent rnd_take is ignored and does not raise underflow.
- in_valid without in_ready: no state change, the beat is not acknowledged.
- Reset asserted mid-fill or mid-hold: all partial chunks and the held word are lost. After release, filling restarts from cnt = 0.
- No bit of a given accepted beat ever appears on rnd_out twice. Assertion: every rnd_valid rising or refresh edge follows exactly NCHUNK accepted beats since the previous transfer, flush or reset.
- No combinational path from in_data to rnd_out.

Test Plan:
- Parameters d=2, NG=3 (RND_W=6), W_IN=4 (NCHUNK=2). After reset release, beats 0xA then 0x5 on consecutive edges -> state FULL after the 2nd edge; the next edge gives rnd_valid=1 and rnd_out=0x1A; in_ready=0 during the FULL cycle.
- Hold rnd_take=0 with a 2nd word (0x3, 0xC) fully buffered -> rnd_out stays 0x1A and in_ready=0. Pulse rnd_take -> at that edge rnd_out=0x03 and rnd_valid stays 1 (no bubble); the next take with nothing buffered -> rnd_valid=0, rnd_out=0.
- rnd_take while rnd_valid=0 -> underflow=1 from the next edge and remains 1 through later traffic, until rst pulses.
- Accept one beat 0xF, then flush together with in_valid=1 and in_data=0x7 -> cnt=0 and buf=0. The next two beats 0x1, 0x2 -> rnd_out=0x21 (no trace of 0xF or 0x7).
- Assert rst asynchronously mid-cycle while rnd_valid=1 -> rnd_valid, rnd_out and in_ready drop immediately without a clock edge. After release, in_ready=1 on the first cycle.
- Randomized PRNG stalls and take patterns with d=3, NG=2, W_IN=5 (RND_W=12, NCHUNK=3) against a scoreboard -> every output word equals the low 12 bits of its 3 concatenated beats, no word is presented twice, and underflow=0.
